// File: rtl/led_monitor_pkg.sv
// Shared constants and state encodings for the LED-to-UART monitor.
// Latency: none (declarations only).
// Backpressure: n/a.
package led_monitor_pkg;

  // ASCII characters used in a report line
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_ONE  = 8'h31;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;

  // Character sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHAR = 2'd1,
    WAIT = 2'd2
  } seq_state_t;

  // Bit phase within one UART frame
  typedef enum logic [1:0] {
    START = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2
  } uart_phase_t;

  // One LED level rendered as its ASCII digit
  function automatic logic [7:0] led_ascii(input logic b);
    return b ? CH_ONE : CH_ZERO;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: start 0, 8 data bits LSB first, stop 1, each bit CLK_DIV cycles.
// Latency: tx drops for the start bit on the clock edge that accepts the byte.
// Backpressure: ready is high when idle and in the last stop-bit cycle, so frames can run back-to-back.
module uart_tx_byte #(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  import led_monitor_pkg::*;

  localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  uart_phase_t       phase;
  logic              active;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bitcnt;
  logic [7:0]        shreg;
  logic              bit_end;

  assign bit_end = (baud == BAUD_LAST);
  // Taking a new byte in the final stop cycle lets its start bit follow with no idle gap.
  assign ready   = !active || ((phase == STOP) && bit_end);

  // Frame shifter: baud counter paces each bit, tx is driven straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx     <= 1'b1;
      active <= 1'b0;
      phase  <= START;
      baud   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else if (valid && ready) begin
      active <= 1'b1;
      phase  <= START;
      baud   <= '0;
      bitcnt <= '0;
      shreg  <= data;
      tx     <= 1'b0;
    end else if (active) begin
      if (!bit_end) begin
        baud <= baud + 1'b1;
      end else begin
        baud <= '0;
        case (phase)
          START: begin
            phase <= DATA;
            tx    <= shreg[0];
          end
          DATA: begin
            if (bitcnt == 3'd7) begin
              phase <= STOP;
              tx    <= 1'b1;
            end else begin
              bitcnt <= bitcnt + 3'd1;
              shreg  <= {1'b0, shreg[7:1]};
              tx     <= shreg[1];
            end
          end
          STOP: begin
            active <= 1'b0;
            tx     <= 1'b1;
          end
          default: begin
            phase <= START;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/led_uart_monitor.sv
// LED observer: reports each new LED state as an ASCII line ("0101\n") on an 8N1 UART pin.
// Latency: led edge -> start bit on the 4th clk edge; a line lasts (NLEDS+1[+1]) x 10 x CLK_DIV cycles.
// Backpressure: none upstream; changes during a line collapse into one follow-up line. LED_MONITOR_CR_EN adds CR before LF.
module led_uart_monitor #(
  parameter int NLEDS   = 4,
  parameter int CLK_DIV = 868
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NLEDS-1:0] led,
  output logic             tx,
  output logic             busy
);
  import led_monitor_pkg::*;

`ifdef LED_MONITOR_CR_EN
  localparam int NCHARS = NLEDS + 2;
`else
  localparam int NCHARS = NLEDS + 1;
`endif
  localparam int IDX_W = $clog2(NLEDS + 2);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NCHARS);

  logic [NLEDS-1:0] led_m;
  logic [NLEDS-1:0] led_s;
  logic [1:0]       primed;
  logic [NLEDS-1:0] last_sent;
  logic [NLEDS-1:0] snap;
  logic             first;
  seq_state_t       state;
  logic [IDX_W-1:0] idx;
  logic             trigger;
  logic [7:0]       ch;
  logic             tx_valid;
  logic             tx_ready;

  // Two-flop synchroniser; primed tracks when led_s holds real pin data after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_m  <= '0;
      led_s  <= '0;
      primed <= '0;
    end else begin
      led_m  <= led;
      led_s  <= led_m;
      primed <= {primed[0], 1'b1};
    end
  end

  // The post-reset report waits for the synchroniser so it carries the live LED value.
  assign trigger  = primed[1] && (first || (led_s != last_sent));
  assign tx_valid = (state == CHAR);
  assign busy     = (state != IDLE);

  // Character for the current index: LED digits led0 first, then optional CR, then LF.
  always_comb begin
    ch = CH_LF;
    for (int i = 0; i < NLEDS; i++) begin
      if (idx == IDX_W'(i)) ch = led_ascii(snap[i]);
    end
`ifdef LED_MONITOR_CR_EN
    if (idx == IDX_W'(NLEDS)) ch = CH_CR;
`endif
  end

  // Sequencer: snapshot on change, then feed one character per frame.
  // WAIT steps back to CHAR at once when characters remain; CHAR then holds valid until the
  // transmitter takes the byte in its last stop cycle. After the final byte, WAIT holds until
  // that frame's stop bit ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      first     <= 1'b1;
      last_sent <= '0;
      snap      <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            snap      <= led_s;
            last_sent <= led_s;
            first     <= 1'b0;
            idx       <= '0;
            state     <= CHAR;
          end
        end
        CHAR: begin
          if (tx_ready) begin
            idx   <= idx + 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (idx != IDX_END) state <= CHAR;
          else if (tx_ready)  state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .data (ch),
    .valid(tx_valid),
    .ready(tx_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_led_uart_monitor.sv
// Directed bench for led_uart_monitor with NLEDS=4, CLK_DIV=4: decodes tx frames and checks bytes,
// bit widths, gaps, line length, busy, change latency, burst collapsing and async reset.
// Honours LED_MONITOR_CR_EN for the expected line tail.
module tb_led_uart_monitor;

  localparam int NLEDS   = 4;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = 10 * CLK_DIV;
`ifdef LED_MONITOR_CR_EN
  localparam int NBYTES = NLEDS + 2;
`else
  localparam int NBYTES = NLEDS + 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NLEDS-1:0] led = '0;
  logic             tx;
  logic             busy;

  int checks = 0;
  int errors = 0;

  led_uart_monitor #(
    .NLEDS  (NLEDS),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .led (led),
    .tx  (tx),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a start bit, then sample all 10 bits over CLK_DIV cycles each.
  task automatic get_byte(input int budget, output logic found, output int w, output logic [7:0] b,
                          output logic stop, output logic stable, output logic busy_all);
    logic v;
    w = 0; found = 1'b0; b = '0; stop = 1'b0; stable = 1'b1; busy_all = 1'b1;
    while (tx !== 1'b0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (tx !== 1'b0) return;
    found = 1'b1;
    for (int k = 0; k < 10; k++) begin
      v = tx;
      if (k >= 1 && k <= 8) b[k-1] = v;
      if (k == 9) stop = v;
      for (int c = 0; c < CLK_DIV; c++) begin
        if (tx !== v) stable = 1'b0;
        if (busy !== 1'b1) busy_all = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  // Receive one report line; leds_exp holds the digit bytes, led0's byte in [7:0].
  // Optional LED changes are applied just before byte index c1 / c2 is awaited.
  task automatic recv_line(input string tag, input logic [31:0] leds_exp,
                           input int c1, input logic [3:0] v1, input int c2, input logic [3:0] v2);
    logic [7:0] exp_b [6];
    logic       found, stop, stable, bsy;
    logic       all_stable, all_busy, all_stop;
    logic [7:0] b;
    int         w, elapsed;
    for (int i = 0; i < NLEDS; i++) exp_b[i] = leds_exp[8*i +: 8];
`ifdef LED_MONITOR_CR_EN
    exp_b[4] = 8'h0D;
    exp_b[5] = 8'h0A;
`else
    exp_b[4] = 8'h0A;
    exp_b[5] = 8'h00;
`endif
    elapsed = 0; all_stable = 1'b1; all_busy = 1'b1; all_stop = 1'b1;
    for (int i = 0; i < NBYTES; i++) begin
      if (i == c1) led = v1;
      if (i == c2) led = v2;
      get_byte(200, found, w, b, stop, stable, bsy);
      check($sformatf("%s start%0d", tag, i), {31'd0, found}, 32'd1);
      if (!found) return;
      check($sformatf("%s byte%0d", tag, i), {24'd0, b}, {24'd0, exp_b[i]});
      if (i > 0) elapsed += w;
      elapsed += FRAME;
      all_stable &= stable;
      all_busy   &= bsy;
      all_stop   &= stop;
    end
    check({tag, " bitwidth"}, {31'd0, all_stable}, 32'd1);
    check({tag, " stopbits"}, {31'd0, all_stop}, 32'd1);
    check({tag, " busy_during"}, {31'd0, all_busy}, 32'd1);
    check({tag, " line_cycles"}, elapsed, NBYTES * FRAME);
    check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, " tx_after"}, {31'd0, tx}, 32'd1);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic measure_latency(input string tag, input int exp);
    int lat;
    lat = 0;
    while (tx !== 1'b0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check(tag, lat, exp);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    led = 4'b0000;
    repeat (3) @(negedge clk);
    check("reset tx", {31'd0, tx}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);

    // First report after reset release
    rst = 1'b0;
    recv_line("boot", {8'h30, 8'h30, 8'h30, 8'h30}, -1, 4'h0, -1, 4'h0);
    expect_quiet("boot idle", 20);

    // Single change from idle: led0 and led2 on
    led = 4'b0101;
    measure_latency("latency 0101", 4);
    recv_line("l0101", {8'h30, 8'h31, 8'h30, 8'h31}, -1, 4'h0, -1, 4'h0);
    expect_quiet("l0101 idle", 20);

    // Burst while busy: 0001 then 0011, 0111 mid-line; only 0111 follows
    led = 4'b0001;
    recv_line("burst", {8'h30, 8'h30, 8'h30, 8'h31}, 1, 4'b0011, 3, 4'b0111);
    recv_line("latest", {8'h30, 8'h31, 8'h31, 8'h31}, -1, 4'h0, -1, 4'h0);
    expect_quiet("no third line", 100);

    // Reset in the middle of a start bit
    led = 4'b1010;
    measure_latency("latency 1010", 4);
    @(negedge clk);
    check("pre-reset tx low", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    #1;
    check("midreset tx", {31'd0, tx}, 32'd1);
    check("midreset busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("held reset tx", {31'd0, tx}, 32'd1);
    rst = 1'b0;
    measure_latency("latency post-reset", 4);
    recv_line("post_rst", {8'h31, 8'h30, 8'h31, 8'h30}, -1, 4'h0, -1, 4'h0);
    expect_quiet("post_rst idle", 20);

    // All LEDs on
    led = 4'b1111;
    recv_line("all_on", {8'h31, 8'h31, 8'h31, 8'h31}, -1, 4'h0, -1, 4'h0);
    expect_quiet("all_on idle", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
